row_deserializer: RTL and testbench

- Upstream of the puzzle-7 splitter core.
- Accepts the padded grid as fixed-width chunks, MSB chunk first, one chunk per enabled cycle, with no input back-pressure.
- Reassembles each full row and hands it downstream through a 2-entry row FIFO with valid/ready.
- Also reports the beam start column found in row 0, and flags frame completion and overflow.

---
 rtl/row_deserializer.sv | 162 ++++++++++++++++
 tb/tb_row_deserializer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/row_deserializer.sv
// rtl/row_deserializer.sv - reassembles chunked grid rows into a 2-entry row FIFO with start-column detect
module row_deserializer #(
    parameter int ROWS      = 142,
    parameter int ROW_WIDTH = 160,
    parameter int CHUNK_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CHUNK_W-1:0]   data,
    input  logic                 enable,
    output logic [ROW_WIDTH-1:0] row_data,
    output logic [7:0]           row_idx,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic [7:0]           start_col,
    output logic                 start_valid,
    output logic                 frame_done,
    output logic                 overflow
);

    localparam int CHUNKS = ROW_WIDTH / CHUNK_W;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int SH_W   = ROW_WIDTH - CHUNK_W;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         chunk_cnt_q, chunk_cnt_d;
    logic [7:0]            row_cnt_q, row_cnt_d;
    logic [SH_W-1:0]       shreg_q, shreg_d;
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;
    logic [ROW_WIDTH-1:0]  head_data_q, head_data_d;
    logic [7:0]            head_idx_q, head_idx_d;
    logic [ROW_WIDTH-1:0]  tail_data_q, tail_data_d;
    logic [7:0]            tail_idx_q, tail_idx_d;
    logic                  row_valid_q, row_valid_d;
    logic [7:0]            start_col_q, start_col_d;
    logic                  start_valid_q, start_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic                  overflow_q, overflow_d;

    logic [ROW_WIDTH-1:0]  assembled;
    logic                  take;
    logic                  row_end;
    logic                  pop;

    // Column index counts from the MSB; 0xFF means the row has no set bit.
    function automatic logic [7:0] leftmost_one(input logic [ROW_WIDTH-1:0] r);
        logic [7:0] idx;
        idx = 8'hFF;
        for (int i = 0; i < ROW_WIDTH; i++) begin
            if (r[i]) idx = 8'(ROW_WIDTH - 1 - i);
        end
        return idx;
    endfunction

    always_comb begin
        assembled     = {shreg_q, data};
        take          = enable && (state_q != DONE);
        row_end       = take && (chunk_cnt_q == CW'(CHUNKS - 1));
        pop           = (fifo_cnt_q != 2'd0) && row_ready;

        state_d       = state_q;
        chunk_cnt_d   = chunk_cnt_q;
        row_cnt_d     = row_cnt_q;
        shreg_d       = shreg_q;
        fifo_cnt_d    = fifo_cnt_q;
        head_data_d   = head_data_q;
        head_idx_d    = head_idx_q;
        tail_data_d   = tail_data_q;
        tail_idx_d    = tail_idx_q;
        start_col_d   = start_col_q;
        start_valid_d = start_valid_q;
        overflow_d    = overflow_q;

        if (take) begin
            shreg_d = assembled[SH_W-1:0];
            if (state_q == IDLE) state_d = FILL;
            if (row_end) begin
                chunk_cnt_d = '0;
                row_cnt_d   = row_cnt_q + 8'd1;
                if (row_cnt_q == 8'(ROWS - 1)) state_d = DONE;
                if (row_cnt_q == 8'd0) begin
                    start_col_d   = leftmost_one(assembled);
                    start_valid_d = 1'b1;
                end
            end else begin
                chunk_cnt_d = chunk_cnt_q + CW'(1);
            end
        end

        // Pop first so that a full FIFO can still accept a same-cycle push.
        if (pop) begin
            fifo_cnt_d = fifo_cnt_q - 2'd1;
            if (fifo_cnt_q == 2'd2) begin
                head_data_d = tail_data_q;
                head_idx_d  = tail_idx_q;
            end
        end

        if (row_end) begin
            if ((fifo_cnt_q != 2'd2) || pop) begin
                if (fifo_cnt_d == 2'd0) begin
                    head_data_d = assembled;
                    head_idx_d  = row_cnt_q;
                end else begin
                    tail_data_d = assembled;
                    tail_idx_d  = row_cnt_q;
                end
                fifo_cnt_d = fifo_cnt_d + 2'd1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        row_valid_d  = (fifo_cnt_d != 2'd0);
        frame_done_d = frame_done_q || ((state_d == DONE) && (fifo_cnt_d == 2'd0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            chunk_cnt_q   <= '0;
            row_cnt_q     <= '0;
            shreg_q       <= '0;
            fifo_cnt_q    <= '0;
            head_data_q   <= '0;
            head_idx_q    <= '0;
            tail_data_q   <= '0;
            tail_idx_q    <= '0;
            row_valid_q   <= 1'b0;
            start_col_q   <= '0;
            start_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            chunk_cnt_q   <= chunk_cnt_d;
            row_cnt_q     <= row_cnt_d;
            shreg_q       <= shreg_d;
            fifo_cnt_q    <= fifo_cnt_d;
            head_data_q   <= head_data_d;
            head_idx_q    <= head_idx_d;
            tail_data_q   <= tail_data_d;
            tail_idx_q    <= tail_idx_d;
            row_valid_q   <= row_valid_d;
            start_col_q   <= start_col_d;
            start_valid_q <= start_valid_d;
            frame_done_q  <= frame_done_d;
            overflow_q    <= overflow_d;
        end
    end

    assign row_data    = head_data_q;
    assign row_idx     = head_idx_q;
    assign row_valid   = row_valid_q;
    assign start_col   = start_col_q;
    assign start_valid = start_valid_q;
    assign frame_done  = frame_done_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_row_deserializer.sv
// tb/tb_row_deserializer.sv - directed self-checking bench for row_deserializer
module tb_row_deserializer;

    localparam int ROWS = 142;
    localparam int RW   = 160;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   data;
    logic          enable;
    logic [RW-1:0] row_data;
    logic [7:0]    row_idx;
    logic          row_valid;
    logic          row_ready;
    logic [7:0]    start_col;
    logic          start_valid;
    logic          frame_done;
    logic          overflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [RW-1:0] got_data[$];
    logic [7:0]    got_idx[$];
    logic [RW-1:0] mem[ROWS];

    row_deserializer dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .enable     (enable),
        .row_data   (row_data),
        .row_idx    (row_idx),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .start_col  (start_col),
        .start_valid(start_valid),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_start(input logic [RW-1:0] r);
        for (int i = 0; i < RW; i++) begin
            if (r[RW-1-i]) return 8'(i);
        end
        return 8'hFF;
    endfunction

    function automatic logic [RW-1:0] rand_row();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: drive inputs, log any row popped at the coming edge, then settle past the edge.
    task automatic cycle(input logic en, input logic [31:0] d, input logic rdy);
        enable    = en;
        data      = d;
        row_ready = rdy;
        if (row_valid && rdy) begin
            got_data.push_back(row_data);
            got_idx.push_back(row_idx);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [RW-1:0] r, input logic rdy);
        for (int c = 0; c < 5; c++) cycle(1'b1, r[RW-1-32*c -: 32], rdy);
    endtask

    task automatic send_row_gaps(input logic [RW-1:0] r);
        for (int c = 0; c < 5; c++) begin
            while ($urandom_range(0, 2) == 0) cycle(1'b0, $urandom, 1'b1);
            cycle(1'b1, r[RW-1-32*c -: 32], 1'b1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(1'b0, 32'h0, 1'b0);
        reset = 1'b0;
        got_data.delete();
        got_idx.delete();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b1);
    endtask

    logic [RW-1:0] ra, rb, rc, rd, re, r1;
    int seen;

    initial begin
        reset = 1'b1; data = '0; enable = 1'b0; row_ready = 1'b0;
        @(posedge clk); #1;
        do_reset();

        check("rst_row_valid", row_valid, 0);
        check("rst_start_valid", start_valid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_row_data", row_data, 0);
        check("rst_row_idx", row_idx, 0);
        check("rst_start_col", start_col, 0);

        // Single MSB bit row, latency of one edge after the last chunk.
        send_row({32'h8000_0000, 128'h0}, 1'b1);
        check("t1_row_valid", row_valid, 1);
        check("t1_row_idx", row_idx, 0);
        check("t1_row_data", row_data, {1'b1, 159'h0});
        check("t1_start_col", start_col, 0);
        check("t1_start_valid", start_valid, 1);

        // Start column in the middle of the row, not disturbed by row 1.
        do_reset();
        r1 = {64'h0, 32'h0000_8000, 64'h0};
        send_row(r1, 1'b1);
        check("t2_start_col0", start_col, 80);
        send_row({32'hFFFF_FFFF, 128'h1}, 1'b1);
        drain(3);
        check("t2_start_col1", start_col, 80);
        check("t2_nrows", got_data.size(), 2);
        check("t2_row0", got_data.size() > 0 ? got_data[0] : 'x, r1);
        check("t2_idx1", got_idx.size() > 1 ? got_idx[1] : 'x, 1);

        // Overflow on the third row with no consumer.
        do_reset();
        ra = rand_row(); rb = rand_row(); rc = rand_row();
        send_row(ra, 1'b0);
        send_row(rb, 1'b0);
        check("t3_no_ovf_yet", overflow, 0);
        send_row(rc, 1'b0);
        check("t3_overflow", overflow, 1);
        check("t3_head_idx", row_idx, 0);
        check("t3_head_data", row_data, ra);
        drain(4);
        check("t3_nrows", got_data.size(), 2);
        check("t3_idx0", got_idx.size() > 0 ? got_idx[0] : 'x, 0);
        check("t3_data0", got_data.size() > 0 ? got_data[0] : 'x, ra);
        check("t3_idx1", got_idx.size() > 1 ? got_idx[1] : 'x, 1);
        check("t3_data1", got_data.size() > 1 ? got_data[1] : 'x, rb);
        check("t3_empty", row_valid, 0);
        check("t3_ovf_sticky", overflow, 1);

        // Push and pop on the same edge with the FIFO full.
        do_reset();
        ra = rand_row(); rb = rand_row(); rc = rand_row();
        send_row(ra, 1'b0);
        send_row(rb, 1'b0);
        for (int c = 0; c < 4; c++) cycle(1'b1, rc[RW-1-32*c -: 32], 1'b0);
        cycle(1'b1, rc[31:0], 1'b1);
        check("t4_overflow", overflow, 0);
        check("t4_row_valid", row_valid, 1);
        check("t4_head_idx", row_idx, 1);
        drain(4);
        check("t4_nrows", got_data.size(), 3);
        check("t4_data0", got_data.size() > 0 ? got_data[0] : 'x, ra);
        check("t4_data1", got_data.size() > 1 ? got_data[1] : 'x, rb);
        check("t4_data2", got_data.size() > 2 ? got_data[2] : 'x, rc);
        check("t4_idx2", got_idx.size() > 2 ? got_idx[2] : 'x, 2);

        // Full frame with random enable gaps.
        do_reset();
        for (int r = 0; r < ROWS; r++) mem[r] = rand_row();
        for (int r = 0; r < ROWS; r++) send_row_gaps(mem[r]);
        check("t5_done_before_drain", frame_done, 0);
        drain(6);
        check("t5_frame_done", frame_done, 1);
        check("t5_nrows", got_data.size(), ROWS);
        check("t5_start_col", start_col, model_start(mem[0]));
        for (int r = 0; r < ROWS; r++) begin
            check($sformatf("t5_idx%0d", r), got_idx.size() > r ? got_idx[r] : 'x, r);
            check($sformatf("t5_data%0d", r), got_data.size() > r ? got_data[r] : 'x, mem[r]);
        end

        // Chunks after the frame are ignored.
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, $urandom, 1'b1);
            if (row_valid) seen++;
        end
        check("t7_no_rows", seen, 0);
        check("t7_overflow", overflow, 0);
        check("t7_frame_done", frame_done, 1);

        // Reset mid-row discards everything and clears sticky flags.
        do_reset();
        check("t6_done_cleared0", frame_done, 0);
        ra = rand_row(); rb = rand_row(); rc = rand_row(); rd = rand_row(); re = rand_row();
        send_row(ra, 1'b0);
        send_row(rb, 1'b0);
        send_row(rc, 1'b0);
        cycle(1'b1, rd[159:128], 1'b0);
        cycle(1'b1, rd[127:96], 1'b0);
        check("t6_ovf_before", overflow, 1);
        do_reset();
        check("t6_overflow", overflow, 0);
        check("t6_start_valid", start_valid, 0);
        check("t6_frame_done", frame_done, 0);
        check("t6_row_valid", row_valid, 0);
        send_row(re, 1'b1);
        drain(3);
        check("t6_nrows", got_data.size(), 1);
        check("t6_idx0", got_idx.size() > 0 ? got_idx[0] : 'x, 0);
        check("t6_data0", got_data.size() > 0 ? got_data[0] : 'x, re);

        // All-zero row 0 reports no start column.
        do_reset();
        send_row('0, 1'b1);
        check("t8_start_col", start_col, 8'hFF);
        check("t8_start_valid", start_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
